// File: rtl/axi_read_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | axi_read_arbiter: shares one AXI4 read master between two AR/R requesters.  |
// | Fixed priority (port 1 first) unless ARB_ROUND_ROBIN_EN is defined.         |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module axi_read_arbiter #(
  parameter int C_M_AXI_THREAD_ID_WIDTH = 1,
  parameter int C_M_AXI_ADDR_WIDTH      = 32,
  parameter int C_M_AXI_DATA_WIDTH      = 32,
  parameter int C_M_AXI_ARUSER_WIDTH    = 1,
  parameter int C_M_AXI_RUSER_WIDTH     = 4
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]      S0_ARADDR,
  input  logic [7:0]                         S0_ARLEN,
  input  logic                               S0_ARVALID,
  output logic                               S0_ARREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]      S0_RDATA,
  output logic                               S0_RLAST,
  output logic                               S0_RVALID,
  input  logic                               S0_RREADY,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]      S1_ARADDR,
  input  logic [7:0]                         S1_ARLEN,
  input  logic                               S1_ARVALID,
  output logic                               S1_ARREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]      S1_RDATA,
  output logic                               S1_RLAST,
  output logic                               S1_RVALID,
  input  logic                               S1_RREADY,
  output logic [1:0]                         GRANT,
  output logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_ARID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]      M_AXI_ARADDR,
  output logic [7:0]                         M_AXI_ARLEN,
  output logic [2:0]                         M_AXI_ARSIZE,
  output logic [1:0]                         M_AXI_ARBURST,
  output logic [1:0]                         M_AXI_ARLOCK,
  output logic [3:0]                         M_AXI_ARCACHE,
  output logic [2:0]                         M_AXI_ARPROT,
  output logic [3:0]                         M_AXI_ARQOS,
  output logic [C_M_AXI_ARUSER_WIDTH-1:0]    M_AXI_ARUSER,
  output logic                               M_AXI_ARVALID,
  input  logic                               M_AXI_ARREADY,
  input  logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_RID,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]      M_AXI_RDATA,
  input  logic [1:0]                         M_AXI_RRESP,
  input  logic                               M_AXI_RLAST,
  input  logic [C_M_AXI_RUSER_WIDTH-1:0]     M_AXI_RUSER,
  input  logic                               M_AXI_RVALID,
  output logic                               M_AXI_RREADY
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t                          r_state;
  logic [1:0]                      r_grant;
  logic                            r_idx;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   r_araddr;
  logic [7:0]                      r_arlen;
  logic                            r_arvalid;

  logic w_win;
  logic w_take;
  logic w_in_data;
  logic w_rready;
  logic w_last_hs;
  logic w_unused_r;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last;

  // On contention the port that did not win last time goes first.
  always_comb begin
    w_win = S1_ARVALID;
    if (S0_ARVALID && S1_ARVALID) w_win = ~r_last;
  end

  always_ff @(posedge CLK) begin
    if (RST)         r_last <= 1'b1;
    else if (w_take) r_last <= w_win;
  end
`else
  assign w_win = S1_ARVALID;
`endif

  assign w_take     = (r_state == S_IDLE) && (S0_ARVALID || S1_ARVALID);
  assign S0_ARREADY = w_take && !w_win;
  assign S1_ARREADY = w_take && w_win;

  assign w_in_data  = (r_state == S_DATA);
  assign w_rready   = w_in_data && ((r_grant[0] && S0_RREADY) || (r_grant[1] && S1_RREADY));
  assign w_last_hs  = M_AXI_RVALID && w_rready && M_AXI_RLAST;

  assign S0_RDATA   = M_AXI_RDATA;
  assign S1_RDATA   = M_AXI_RDATA;
  assign S0_RVALID  = w_in_data && r_grant[0] && M_AXI_RVALID;
  assign S1_RVALID  = w_in_data && r_grant[1] && M_AXI_RVALID;
  assign S0_RLAST   = w_in_data && r_grant[0] && M_AXI_RLAST;
  assign S1_RLAST   = w_in_data && r_grant[1] && M_AXI_RLAST;
  assign M_AXI_RREADY = w_rready;

  assign GRANT         = r_grant;
  assign M_AXI_ARID    = C_M_AXI_THREAD_ID_WIDTH'(r_idx);
  assign M_AXI_ARADDR  = r_araddr;
  assign M_AXI_ARLEN   = r_arlen;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_ARSIZE  = 3'b010;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARLOCK  = 2'b00;
  assign M_AXI_ARCACHE = 4'b0011;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARQOS   = 4'b0000;
  assign M_AXI_ARUSER  = '0;

  // Read-side ID, response and user bits carry nothing this arbiter acts on.
  assign w_unused_r = ^{M_AXI_RID, M_AXI_RRESP, M_AXI_RUSER};

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_grant   <= 2'b00;
      r_idx     <= 1'b0;
      r_araddr  <= '0;
      r_arlen   <= 8'd0;
      r_arvalid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_idx     <= w_win;
            r_grant   <= w_win ? 2'b10 : 2'b01;
            r_araddr  <= w_win ? S1_ARADDR : S0_ARADDR;
            r_arlen   <= w_win ? S1_ARLEN : S0_ARLEN;
            r_arvalid <= 1'b1;
            r_state   <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (M_AXI_ARREADY) begin
            r_arvalid <= 1'b0;
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_last_hs) begin
            r_grant <= 2'b00;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
